// File: rtl/lock_seq_checker.sv
// Three-symbol code-lock sequence checker with a failed-entry counter and lockout.
// Optional macro ENTRY_TIMEOUT_EN adds an inter-symbol timeout that counts as a failed entry.
module lock_seq_checker #(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] code0,
  input  logic [4:0] code1,
  input  logic [4:0] code2,
  input  logic [4:0] symIn,
  input  logic       symValid,
  input  logic       relock,
  output logic       ready,
  output logic       unlocked,
  output logic       fail,
  output logic       lockout,
  output logic [2:0] attempts
);

  typedef enum logic [2:0] {WAIT0, WAIT1, WAIT2, OPEN, LOCKED} state_e;

  localparam logic [2:0] MaxTries    = 3'(MAX_TRIES);
  localparam logic [7:0] LockoutLoad = 8'(LOCKOUT_CYCLES);

  state_e     state_q, state_d;
  logic       mismatch_q, mismatch_d;
  logic [2:0] attempts_q, attempts_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       ready_q, ready_d;
  logic       unlocked_q, unlocked_d;
  logic       fail_q, fail_d;
  logic       lockout_q, lockout_d;
  logic       entry_done, entry_bad;

`ifdef ENTRY_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] timer_q, timer_d;
`endif

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    mismatch_d = mismatch_q;
    attempts_d = attempts_q;
    lock_cnt_d = lock_cnt_q;
    fail_d     = 1'b0;
    entry_done = 1'b0;
    entry_bad  = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
    timer_d    = timer_q;
`endif

    unique case (state_q)
      WAIT0: begin
        if (symValid) begin
          mismatch_d = (symIn != code0);
          state_d    = WAIT1;
`ifdef ENTRY_TIMEOUT_EN
          timer_d    = '0;
`endif
        end
      end
      WAIT1, WAIT2: begin
        // An abort beats a symbol arriving on the same edge.
        if (relock) begin
          state_d    = WAIT0;
          mismatch_d = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
          timer_d    = '0;
`endif
        end else if (symValid) begin
          if (state_q == WAIT1) begin
            mismatch_d = mismatch_q | (symIn != code1);
            state_d    = WAIT2;
`ifdef ENTRY_TIMEOUT_EN
            timer_d    = '0;
`endif
          end else begin
            entry_done = 1'b1;
            entry_bad  = mismatch_q | (symIn != code2);
          end
        end
`ifdef ENTRY_TIMEOUT_EN
        else if (timer_q == TimeoutLast) begin
          entry_done = 1'b1;
          entry_bad  = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
`endif
      end
      OPEN: begin
        if (relock) state_d = WAIT0;
      end
      LOCKED: begin
        lock_cnt_d = lock_cnt_q - 8'd1;
        if (lock_cnt_q == 8'd1) begin
          state_d    = WAIT0;
          attempts_d = '0;
        end
      end
      default: state_d = WAIT0;
    endcase

    if (entry_done) begin
      mismatch_d = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      timer_d    = '0;
`endif
      if (!entry_bad) begin
        state_d    = OPEN;
        attempts_d = '0;
      end else begin
        fail_d     = 1'b1;
        attempts_d = attempts_q + 3'd1;
        if (attempts_q + 3'd1 == MaxTries) begin
          state_d    = LOCKED;
          lock_cnt_d = LockoutLoad;
        end else begin
          state_d = WAIT0;
        end
      end
    end

    ready_d    = (state_d == WAIT0) || (state_d == WAIT1) || (state_d == WAIT2);
    unlocked_d = (state_d == OPEN);
    lockout_d  = (state_d == LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= WAIT0;
      mismatch_q <= 1'b0;
      attempts_q <= '0;
      lock_cnt_q <= '0;
      ready_q    <= 1'b1;
      unlocked_q <= 1'b0;
      fail_q     <= 1'b0;
      lockout_q  <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      timer_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mismatch_q <= mismatch_d;
      attempts_q <= attempts_d;
      lock_cnt_q <= lock_cnt_d;
      ready_q    <= ready_d;
      unlocked_q <= unlocked_d;
      fail_q     <= fail_d;
      lockout_q  <= lockout_d;
`ifdef ENTRY_TIMEOUT_EN
      timer_q    <= timer_d;
`endif
    end
  end

  assign ready    = ready_q;
  assign unlocked = unlocked_q;
  assign fail     = fail_q;
  assign lockout  = lockout_q;
  assign attempts = attempts_q;

endmodule

// File: tb/tb_lock_seq_checker.sv
// Self-checking bench for lock_seq_checker: directed scenarios plus random traffic
// compared every cycle against an entry-level behavioural model.
module tb_lock_seq_checker;

  localparam int MAX_TRIES      = 3;
  localparam int LOCKOUT_CYCLES = 16;
  localparam int TIMEOUT_CYCLES = 32;

  localparam logic [4:0] C0 = 5'b11110;
  localparam logic [4:0] C1 = 5'b10110;
  localparam logic [4:0] C2 = 5'b00011;
  localparam logic [4:0] BAD = 5'b00000;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [4:0] code0 = C0, code1 = C1, code2 = C2;
  logic [4:0] symIn = '0;
  logic       symValid = 1'b0;
  logic       relock = 1'b0;
  logic       ready, unlocked, fail, lockout;
  logic [2:0] attempts;

  int checks = 0;
  int errors = 0;

  lock_seq_checker #(
    .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .CLK(CLK), .RST(RST), .code0(code0), .code1(code1), .code2(code2),
    .symIn(symIn), .symValid(symValid), .relock(relock),
    .ready(ready), .unlocked(unlocked), .fail(fail), .lockout(lockout), .attempts(attempts)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Entry-level model: the symbols of the entry in progress are a queue of hit bits.
  bit m_hits[$];
  bit m_open;
  int m_lock_left;
  int m_attempts;
  bit m_fail;
  int m_idle;

  function automatic logic [4:0] code_at(input int pos);
    return (pos == 0) ? code0 : (pos == 1) ? code1 : code2;
  endfunction

  function automatic void finish_entry(input bit good);
    m_hits.delete();
    m_idle = 0;
    if (good) begin
      m_open = 1'b1;
      m_attempts = 0;
    end else begin
      m_fail = 1'b1;
      m_attempts++;
      if (m_attempts == MAX_TRIES) m_lock_left = LOCKOUT_CYCLES;
    end
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_hits.delete();
      m_open = 0; m_lock_left = 0; m_attempts = 0; m_fail = 0; m_idle = 0;
    end else begin
      m_fail = 1'b0;
      if (m_lock_left > 0) begin
        m_lock_left--;
        if (m_lock_left == 0) m_attempts = 0;
      end else if (m_open) begin
        if (relock) m_open = 1'b0;
      end else if (relock && m_hits.size() > 0) begin
        m_hits.delete();
        m_idle = 0;
      end else if (symValid) begin
        m_hits.push_back(symIn == code_at(m_hits.size()));
        m_idle = 0;
        if (m_hits.size() == 3) finish_entry(m_hits[0] && m_hits[1] && m_hits[2]);
      end
`ifdef ENTRY_TIMEOUT_EN
      else if (m_hits.size() > 0) begin
        m_idle++;
        if (m_idle == TIMEOUT_CYCLES) finish_entry(1'b0);
      end
`endif
    end
  end

  always @(negedge CLK) begin
    check("ready",    int'(ready),    int'(!m_open && m_lock_left == 0));
    check("unlocked", int'(unlocked), int'(m_open));
    check("fail",     int'(fail),     int'(m_fail));
    check("lockout",  int'(lockout),  int'(m_lock_left > 0));
    check("attempts", int'(attempts), m_attempts);
  end

  task automatic drive(input logic v, input logic [4:0] s, input logic r);
    symValid = v; symIn = s; relock = r;
    @(negedge CLK);
  endtask

  task automatic bad_entry();
    drive(1'b1, C0, 1'b0); drive(1'b1, C1, 1'b0); drive(1'b1, BAD, 1'b0);
  endtask

  initial begin
    int n;
    #8;
    check("rst_ready", int'(ready), 1);
    check("rst_unlocked", int'(unlocked), 0);
    check("rst_fail", int'(fail), 0);
    check("rst_lockout", int'(lockout), 0);
    check("rst_attempts", int'(attempts), 0);
    #4 RST = 1'b1;
    @(negedge CLK);

    // Correct entry, then relock from OPEN.
    drive(1'b1, C0, 1'b0); drive(1'b1, C1, 1'b0); drive(1'b1, C2, 1'b0);
    check("open_unlocked", int'(unlocked), 1);
    check("open_attempts", int'(attempts), 0);
    check("open_ready", int'(ready), 0);
    drive(1'b1, C0, 1'b0);
    check("open_holds", int'(unlocked), 1);
    drive(1'b0, '0, 1'b1);
    check("relock_unlocked", int'(unlocked), 0);
    check("relock_ready", int'(ready), 1);

    // Late error: mismatch on the last symbol only.
    bad_entry();
    check("late_fail", int'(fail), 1);
    check("late_attempts", int'(attempts), 1);
    check("late_ready", int'(ready), 1);
    drive(1'b0, '0, 1'b0);
    check("late_fail_pulse", int'(fail), 0);
    check("late_unlocked", int'(unlocked), 0);

    // Two more failures reach lockout; symbols offered during it are ignored.
    bad_entry();
    check("second_attempts", int'(attempts), 2);
    bad_entry();
    check("lock_fail", int'(fail), 1);
    check("lock_level", int'(lockout), 1);
    check("lock_attempts", int'(attempts), 3);
    n = 1;
    for (int i = 0; i < 40 && lockout; i++) begin
      drive(1'b1, (i % 3 == 0) ? C0 : (i % 3 == 1) ? C1 : C2, 1'b0);
      if (lockout) n++;
    end
    check("lock_cycles", n, LOCKOUT_CYCLES);
    check("lock_end_attempts", int'(attempts), 0);
    check("lock_end_ready", int'(ready), 1);
    drive(1'b0, '0, 1'b0);

    // Abort after the first symbol, and relock colliding with a symbol.
    bad_entry();
    drive(1'b1, C0, 1'b0);
    drive(1'b0, '0, 1'b1);
    check("abort_fail", int'(fail), 0);
    check("abort_attempts", int'(attempts), 1);
    drive(1'b1, C0, 1'b0);
    drive(1'b1, C1, 1'b1);
    drive(1'b1, C0, 1'b0); drive(1'b1, C1, 1'b0); drive(1'b1, C2, 1'b0);
    check("abort_then_open", int'(unlocked), 1);
    drive(1'b0, '0, 1'b1);

    // Code change mid-entry applies only to later symbols.
    drive(1'b1, C0, 1'b0);
    code0 = BAD;
    drive(1'b1, C1, 1'b0); drive(1'b1, C2, 1'b0);
    check("code_change_open", int'(unlocked), 1);
    code0 = C0;
    drive(1'b0, '0, 1'b1);

    // Asynchronous reset during lockout.
    bad_entry(); bad_entry(); bad_entry();
    check("pre_rst_lockout", int'(lockout), 1);
    #2 RST = 1'b0;
    #1;
    check("arst_lockout", int'(lockout), 0);
    check("arst_attempts", int'(attempts), 0);
    check("arst_ready", int'(ready), 1);
    check("arst_fail", int'(fail), 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

`ifdef ENTRY_TIMEOUT_EN
    drive(1'b1, C0, 1'b0);
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) drive(1'b0, '0, 1'b0);
    check("tmo_before", int'(fail), 0);
    drive(1'b0, '0, 1'b0);
    check("tmo_fail", int'(fail), 1);
    check("tmo_attempts", int'(attempts), 1);
`endif

    // Random traffic, mostly correct symbols so every state is visited.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] s;
      if ($urandom_range(0, 99) < 3) code1 = ($urandom_range(0, 1) != 0) ? C1 : 5'($urandom);
      s = (m_hits.size() < 3 && $urandom_range(0, 99) < 80) ? code_at(m_hits.size()) : 5'($urandom);
      drive($urandom_range(0, 99) < 60, s, $urandom_range(0, 99) < 8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lock_seq_checker.md
LOCK_SEQ_CHECKER -- requirements
Module: lock_seq_checker

Interface
REQ-001 Parameter MAX_TRIES, default 3: consecutive failed entries that trigger lockout; legal range 1..7.
REQ-002 Parameter LOCKOUT_CYCLES, default 16: lockout duration in CLK cycles; legal range 1..255.
REQ-003 Parameter TIMEOUT_CYCLES, default 32: inter-symbol timeout in CLK cycles (used only with ENTRY_TIMEOUT_EN); legal range 1..255.
REQ-004 CLK  in  1  single clock; all state changes on the rising edge.
REQ-005 RST  in  1  asynchronous, active-low reset.
REQ-006 code0, code1, code2  in  5 each  stored code symbols, fed from the register file read ports 0/1/2.
REQ-007 symIn  in  5  entered symbol.
REQ-008 symValid  in  1  symIn is valid this cycle.
REQ-009 relock  in  1  request to re-lock, or to abort the current entry.
REQ-010 ready  out  1  the block accepts a symbol this cycle.
REQ-011 unlocked  out  1  level; the correct code was entered.
REQ-012 fail  out  1  one-cycle pulse on each failed entry.
REQ-013 lockout  out  1  level; the block is in the lockout period.
REQ-014 attempts  out  3  current consecutive-failure count.

Function
REQ-015 FSM states: WAIT0, WAIT1, WAIT2, OPEN, LOCKED.
REQ-016 ready SHALL be 1 in WAIT0, WAIT1 and WAIT2, and 0 in OPEN and LOCKED.
REQ-017 A symbol is accepted when ready and symValid are both 1 on a rising edge; symValid while ready=0 SHALL be ignored with no state change.
REQ-018 On acceptance in WAITn, symIn SHALL be compared with codeN as sampled on that edge; a mismatch sets a sticky mismatch flag, and the FSM advances WAIT0->WAIT1->WAIT2.
REQ-019 No early reject: the block SHALL accept all three symbols before it reports a result.
REQ-020 Acceptance in WAIT2 with no mismatch (including the third symbol): next state OPEN, unlocked=1 from the following cycle, attempts cleared to 0, mismatch flag cleared.
REQ-021 Acceptance in WAIT2 with a mismatch: fail=1 for exactly the next cycle, attempts incremented, mismatch flag cleared, next state WAIT0.
REQ-022 If the increment in REQ-021 makes attempts equal MAX_TRIES, the next state SHALL be LOCKED instead of WAIT0, with the lockout counter loaded with LOCKOUT_CYCLES; fail SHALL still pulse.
REQ-023 LOCKED: lockout=1 and the counter decrements every cycle; when it reaches 0 the FSM SHALL go to WAIT0 and clear attempts. Total lockout duration is LOCKOUT_CYCLES cycles.
REQ-024 OPEN SHALL hold until relock=1, then go to WAIT0 with unlocked=0 from the following cycle.
REQ-025 relock=1 in WAIT1 or WAIT2 SHALL abort to WAIT0 and clear the mismatch flag; this does not count as a failure and does not pulse fail.
REQ-026 relock=1 in WAIT0 or LOCKED SHALL be ignored.
REQ-027 relock and an accepted symbol on the same edge: relock wins and the symbol is discarded.
REQ-028 A change on code0..2 mid-entry affects only symbols accepted after the change.

Reset
REQ-029 While RST=0, the block SHALL hold: state WAIT0, ready=1, unlocked=0, fail=0, lockout=0, attempts=0, mismatch flag cleared, all counters at 0.
REQ-030 Reset asserted mid-entry or during LOCKED SHALL abort immediately (asynchronously); the next entry starts fresh after RST deasserts.

Configuration
REQ-031 Macro ENTRY_TIMEOUT_EN, when defined: a timer restarts on each acceptance. TIMEOUT_CYCLES cycles without an acceptance in WAIT1 or WAIT2 SHALL be treated as a failed entry per REQ-021/REQ-022, including the fail pulse and the attempts increment.
REQ-032 Without ENTRY_TIMEOUT_EN: no timer logic is compiled in, and WAIT1 and WAIT2 wait indefinitely.

Verification
REQ-033 Setup for all scenarios: code0/1/2 = 11110, 10110, 00011.
REQ-034 Correct entry: enter 11110, 10110, 00011 -> unlocked=1 the cycle after the third acceptance; attempts=0; ready=0.
REQ-035 Late-error entry: enter 11110, 10110, 00000 -> fail pulses for 1 cycle; attempts=1; state WAIT0; unlocked stays 0.
REQ-036 Lockout: three wrong entries -> lockout=1 for exactly 16 cycles; symValid is ignored throughout; then attempts=0 and ready=1.
REQ-037 Abort and relock: relock after the first symbol -> WAIT0, no fail pulse, attempts unchanged; relock in OPEN -> unlocked=0 the next cycle.
REQ-038 Reset and timeout: RST=0 during LOCKED -> all outputs return to reset values at once. With ENTRY_TIMEOUT_EN, one symbol then 32 idle cycles -> fail pulse and attempts+1.
